// File: rtl/rpn_alu_pkg.sv
// Shared types and constants for the RPN ALU datapath.
package rpn_alu_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } rpn_state_t;

   localparam int RPN_WIDTH   = 8;
   localparam int RPN_NUM_OPS = 8;

   localparam int OP_AND = 4;
   localparam int OP_OR  = 5;
   localparam int OP_XOR = 6;
   localparam int OP_NOT = 7;

endpackage

// File: rtl/rpn_op_select.sv
// Combinational operation select with range check and result flags.
module rpn_op_select #(
   parameter int  WIDTH   = 8,
   parameter int  NUM_OPS = 8,
   localparam int SEL_W   = $clog2(NUM_OPS)
) (
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_OPS*WIDTH-1:0] ops,
   output logic [WIDTH-1:0]         value,
   output logic                     zero,
   output logic                     neg,
   output logic                     sel_err
);

   // An index matching no operation leaves value at zero and flags the error.
   always_comb begin
      value   = '0;
      sel_err = 1'b1;
      for (int k = 0; k < NUM_OPS; k++) begin
         if (sel == SEL_W'(k)) begin
            value   = ops[k*WIDTH +: WIDTH];
            sel_err = 1'b0;
         end
      end
   end

   assign zero = (value == '0);
   assign neg  = value[WIDTH-1];

endmodule

// File: rtl/rpn_result_selector.sv
// Result selector with flag generation and a 2-entry skid buffer on the output.
module rpn_result_selector
   import rpn_alu_pkg::*;
#(
   parameter int  WIDTH   = RPN_WIDTH,
   parameter int  NUM_OPS = RPN_NUM_OPS,
   localparam int SEL_W   = $clog2(NUM_OPS)
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [SEL_W-1:0]         SEL,
   input  logic [NUM_OPS*WIDTH-1:0] OPS,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [WIDTH-1:0]         RESULT,
   output logic [SEL_W-1:0]         OUT_SEL,
   output logic                     ZERO,
   output logic                     NEG,
   output logic                     SEL_ERR
);

   typedef struct packed {
      logic             err;
      logic             neg;
      logic             zero;
      logic [SEL_W-1:0] sel;
      logic [WIDTH-1:0] value;
   } entry_t;

   rpn_state_t       state, state_nxt;
   entry_t           cur, out_q, skid_q;
   logic [WIDTH-1:0] cur_value;
   logic             cur_zero, cur_neg, cur_err;
   logic             in_xfer, out_xfer;
   logic             ld_out_in, ld_out_skid, ld_skid;

   rpn_op_select #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) u_sel (
      .sel     (SEL),
      .ops     (OPS),
      .value   (cur_value),
      .zero    (cur_zero),
      .neg     (cur_neg),
      .sel_err (cur_err)
   );

   assign cur = '{err: cur_err, neg: cur_neg, zero: cur_zero, sel: SEL, value: cur_value};

   // Ready depends on state only, so OUT_READY never reaches IN_READY combinationally.
   assign IN_READY  = (state != TWO);
   assign OUT_VALID = (state != EMPTY);
   assign in_xfer   = IN_VALID & IN_READY;
   assign out_xfer  = OUT_VALID & OUT_READY;

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      ld_out_in   = 1'b0;
      ld_out_skid = 1'b0;
      ld_skid     = 1'b0;
      unique case (state)
         EMPTY: begin
            if (in_xfer) begin
               ld_out_in = 1'b1;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               ld_out_in = 1'b1;
            end else if (in_xfer) begin
               ld_skid   = 1'b1;
               state_nxt = TWO;
            end else if (out_xfer) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (out_xfer) begin
               ld_out_skid = 1'b1;
               state_nxt   = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (ld_out_in)        out_q <= cur;
         else if (ld_out_skid) out_q <= skid_q;
         if (ld_skid)          skid_q <= cur;
      end
   end

   assign RESULT  = out_q.value;
   assign OUT_SEL = out_q.sel;
   assign ZERO    = out_q.zero;
   assign NEG     = out_q.neg;
   assign SEL_ERR = out_q.err;

endmodule

// File: tb/tb_rpn_result_selector.sv
// Directed bench: default build, NUM_OPS=6 build and WIDTH=16/NUM_OPS=16 build.
module tb_rpn_result_selector;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   // default build (8/8)
   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic [2:0]  sel_a, out_sel_a;
   logic [63:0] ops_a;
   logic [7:0]  result_a;
   logic        zero_a, neg_a, sel_err_a;

   // 8-bit, 6 operations
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [2:0]  sel_b, out_sel_b;
   logic [47:0] ops_b;
   logic [7:0]  result_b;
   logic        zero_b, neg_b, sel_err_b;

   // 16-bit, 16 operations
   logic         in_valid_c, in_ready_c, out_valid_c, out_ready_c;
   logic [3:0]   sel_c, out_sel_c;
   logic [255:0] ops_c;
   logic [15:0]  result_c;
   logic         zero_c, neg_c, sel_err_c;

   rpn_result_selector u_dut_a (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid_a), .IN_READY(in_ready_a),
      .SEL(sel_a), .OPS(ops_a), .OUT_VALID(out_valid_a), .OUT_READY(out_ready_a),
      .RESULT(result_a), .OUT_SEL(out_sel_a), .ZERO(zero_a), .NEG(neg_a), .SEL_ERR(sel_err_a)
   );

   rpn_result_selector #(.WIDTH(8), .NUM_OPS(6)) u_dut_b (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid_b), .IN_READY(in_ready_b),
      .SEL(sel_b), .OPS(ops_b), .OUT_VALID(out_valid_b), .OUT_READY(out_ready_b),
      .RESULT(result_b), .OUT_SEL(out_sel_b), .ZERO(zero_b), .NEG(neg_b), .SEL_ERR(sel_err_b)
   );

   rpn_result_selector #(.WIDTH(16), .NUM_OPS(16)) u_dut_c (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid_c), .IN_READY(in_ready_c),
      .SEL(sel_c), .OPS(ops_c), .OUT_VALID(out_valid_c), .OUT_READY(out_ready_c),
      .RESULT(result_c), .OUT_SEL(out_sel_c), .ZERO(zero_c), .NEG(neg_c), .SEL_ERR(sel_err_c)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid_a = 0; out_ready_a = 0; sel_a = '0; ops_a = '0;
      in_valid_b = 0; out_ready_b = 0; sel_b = '0; ops_b = '0;
      in_valid_c = 0; out_ready_c = 0; sel_c = '0; ops_c = '0;
      step();
      step();
      rst_n = 1'b1;

      // reset state
      chk("rst_in_ready",  32'(in_ready_a), 32'd1);
      chk("rst_out_valid", 32'(out_valid_a), 32'd0);
      chk("rst_result",    32'(result_a), 32'd0);
      chk("rst_out_sel",   32'(out_sel_a), 32'd0);
      chk("rst_zero",      32'(zero_a), 32'd0);
      chk("rst_neg",       32'(neg_a), 32'd0);
      chk("rst_sel_err",   32'(sel_err_a), 32'd0);

      // single op, one-cycle latency
      ops_a[5*8 +: 8] = 8'h3C;
      sel_a = 3'd5; in_valid_a = 1; out_ready_a = 1;
      step();
      in_valid_a = 0;
      chk("single_valid",  32'(out_valid_a), 32'd1);
      chk("single_result", 32'(result_a), 32'h3C);
      chk("single_sel",    32'(out_sel_a), 32'd5);
      chk("single_zero",   32'(zero_a), 32'd0);
      chk("single_neg",    32'(neg_a), 32'd0);
      step();
      chk("single_drained", 32'(out_valid_a), 32'd0);

      // backpressure fill to TWO
      out_ready_a = 0;
      ops_a = '0;
      ops_a[7*8 +: 8] = 8'h80;
      ops_a[3*8 +: 8] = 8'h55;
      sel_a = 3'd7; in_valid_a = 1;
      step();
      chk("bp_first_result", 32'(result_a), 32'h80);
      chk("bp_first_ready",  32'(in_ready_a), 32'd1);
      sel_a = 3'd0;
      step();
      chk("bp_two_ready",  32'(in_ready_a), 32'd0);
      chk("bp_two_result", 32'(result_a), 32'h80);
      chk("bp_two_neg",    32'(neg_a), 32'd1);
      sel_a = 3'd3;  // offered while full; must be ignored
      step();
      in_valid_a = 0;
      chk("bp_hold_valid",  32'(out_valid_a), 32'd1);
      chk("bp_hold_result", 32'(result_a), 32'h80);
      chk("bp_hold_sel",    32'(out_sel_a), 32'd7);
      chk("bp_hold_neg",    32'(neg_a), 32'd1);
      chk("bp_hold_ready",  32'(in_ready_a), 32'd0);
      out_ready_a = 1;
      step();
      chk("bp_drain1_valid",  32'(out_valid_a), 32'd1);
      chk("bp_drain1_result", 32'(result_a), 32'h00);
      chk("bp_drain1_zero",   32'(zero_a), 32'd1);
      chk("bp_drain1_sel",    32'(out_sel_a), 32'd0);
      chk("bp_drain1_ready",  32'(in_ready_a), 32'd1);
      step();
      chk("bp_drain2_valid", 32'(out_valid_a), 32'd0);

      // back-to-back streaming
      for (int k = 0; k < 8; k++) ops_a[k*8 +: 8] = 8'(k + 1);
      for (int k = 0; k < 8; k++) begin
         sel_a = 3'(k); in_valid_a = 1;
         step();
         chk("stream_valid",  32'(out_valid_a), 32'd1);
         chk("stream_result", 32'(result_a), 32'(k + 1));
         chk("stream_ready",  32'(in_ready_a), 32'd1);
      end
      in_valid_a = 0;
      step();
      chk("stream_end_valid", 32'(out_valid_a), 32'd0);

      // reset while two entries are held
      out_ready_a = 0;
      sel_a = 3'd1; in_valid_a = 1;
      step();
      sel_a = 3'd2;
      step();
      in_valid_a = 0;
      chk("mid_two_ready", 32'(in_ready_a), 32'd0);
      rst_n = 0;
      step();
      rst_n = 1;
      chk("mid_rst_valid",  32'(out_valid_a), 32'd0);
      chk("mid_rst_result", 32'(result_a), 32'd0);
      chk("mid_rst_ready",  32'(in_ready_a), 32'd1);
      out_ready_a = 1;
      step();
      chk("mid_no_stale", 32'(out_valid_a), 32'd0);

      // out-of-range select, NUM_OPS=6
      for (int k = 0; k < 6; k++) ops_b[k*8 +: 8] = 8'(8'h11 * (k + 1));
      out_ready_b = 1;
      sel_b = 3'd7; in_valid_b = 1;
      step();
      chk("oor_valid",   32'(out_valid_b), 32'd1);
      chk("oor_result",  32'(result_b), 32'd0);
      chk("oor_zero",    32'(zero_b), 32'd1);
      chk("oor_neg",     32'(neg_b), 32'd0);
      chk("oor_sel_err", 32'(sel_err_b), 32'd1);
      chk("oor_out_sel", 32'(out_sel_b), 32'd7);
      sel_b = 3'd2;
      step();
      in_valid_b = 0;
      chk("oor_next_result",  32'(result_b), 32'h33);
      chk("oor_next_sel_err", 32'(sel_err_b), 32'd0);
      chk("oor_next_zero",    32'(zero_b), 32'd0);

      // width scaling, WIDTH=16 NUM_OPS=16
      ops_c[15*16 +: 16] = 16'h8001;
      out_ready_c = 1;
      sel_c = 4'd15; in_valid_c = 1;
      step();
      in_valid_c = 0;
      chk("w16_valid",   32'(out_valid_c), 32'd1);
      chk("w16_result",  32'(result_c), 32'h8001);
      chk("w16_neg",     32'(neg_c), 32'd1);
      chk("w16_zero",    32'(zero_c), 32'd0);
      chk("w16_sel_err", 32'(sel_err_c), 32'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
